// File: rtl/mcdt_formatter.sv
// Buffers the mcdt stream in three per-channel FIFOs and emits framed packets
// (header + PKT_LEN words) over a request/grant, valid/ready output port.
module mcdt_formatter #(
   parameter int FIFO_DEPTH = 32,
   parameter int PKT_LEN    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] mcdt_data_i,
   input  logic        mcdt_val_i,
   input  logic [1:0]  mcdt_id_i,
   output logic        fmt_req_o,
   output logic [1:0]  fmt_chid_o,
   input  logic        fmt_grant_i,
   output logic [31:0] fmt_data_o,
   output logic        fmt_valid_o,
   input  logic        fmt_ready_i,
   output logic        fmt_start_o,
   output logic        fmt_end_o,
   output logic [2:0]  ovf_o,
   output logic        id_err_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] PKT_C   = (AW+1)'(PKT_LEN);
   localparam logic [7:0]  PKT8_C  = 8'(PKT_LEN);

   typedef enum logic [1:0] {IDLE, REQ, HDR, DATA} state_t;

   state_t         state_q, state_d;
   logic [31:0]    mem [3][FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q [3];
   logic [AW-1:0]  rd_ptr_q [3];
   logic [AW:0]    cnt_q [3];
   logic [2:0]     push, pop, full, elig;
   logic [1:0]     chid_q, rr_q, win, cand;
   logic [7:0]     beat_q;
   logic           last_beat, any_elig;

   assign last_beat = (beat_q == PKT8_C - 8'd1);
   assign any_elig  = |elig;

   always_comb begin
      for (int c = 0; c < 3; c++) begin
         full[c] = (cnt_q[c] == DEPTH_C);
         elig[c] = (cnt_q[c] >= PKT_C);
         // Full is judged on the current count: a same-cycle pop does not save the word.
         push[c] = mcdt_val_i && (mcdt_id_i == c[1:0]) && !full[c];
         pop[c]  = (state_q == DATA) && (chid_q == c[1:0]) && fmt_ready_i;
      end
   end

   // Round-robin: search starts one past the last served channel.
   always_comb begin
      win  = rr_q;
      cand = rr_q;
      for (int i = 3; i >= 1; i--) begin
         cand = 2'((int'(rr_q) + i) % 3);
         if (elig[cand]) win = cand;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int c = 0; c < 3; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
            cnt_q[c]    <= '0;
         end
         ovf_o    <= '0;
         id_err_o <= 1'b0;
      end else begin
         for (int c = 0; c < 3; c++) begin
            if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
            if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
            cnt_q[c] <= cnt_q[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
            if (mcdt_val_i && (mcdt_id_i == c[1:0]) && full[c]) ovf_o[c] <= 1'b1;
         end
         if (mcdt_val_i && (mcdt_id_i == 2'd3)) id_err_o <= 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; pointers and counts define what is valid.
   always_ff @(posedge clk_i) begin
      for (int c = 0; c < 3; c++)
         if (push[c]) mem[c][wr_ptr_q[c]] <= mcdt_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         chid_q <= 2'd0;
         beat_q <= 8'd0;
         rr_q   <= 2'd2;
      end else begin
         if (state_q == IDLE && any_elig) chid_q <= win;
         if (state_q == HDR) beat_q <= 8'd0;
         if (state_q == DATA && fmt_ready_i) begin
            beat_q <= beat_q + 8'd1;
            if (last_beat) rr_q <= chid_q;
         end
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      fmt_valid_o = 1'b0;
      fmt_start_o = 1'b0;
      fmt_end_o   = 1'b0;
      fmt_data_o  = 32'h0;
      case (state_q)
         IDLE: if (any_elig) state_d = REQ;
         REQ:  if (fmt_grant_i) state_d = HDR;
         HDR: begin
            fmt_valid_o = 1'b1;
            fmt_start_o = 1'b1;
            fmt_data_o  = {8'hA5, 6'h0, chid_q, 8'h00, PKT8_C};
            if (fmt_ready_i) state_d = DATA;
         end
         DATA: begin
            fmt_valid_o = 1'b1;
            fmt_end_o   = last_beat;
            fmt_data_o  = mem[chid_q][rd_ptr_q[chid_q]];
            if (fmt_ready_i && last_beat) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign fmt_req_o  = (state_q == REQ);
   assign fmt_chid_o = chid_q;

endmodule

// File: tb/tb_mcdt_formatter.sv
// Scoreboard bench for mcdt_formatter: directed writes queue expected packet words,
// an independent monitor checks every accepted output word.
module tb_mcdt_formatter;

   typedef struct packed {
      logic [31:0] data;
      logic        start;
      logic        last;
      logic [1:0]  chid;
   } beat_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] mcdt_data_i = '0;
   logic        mcdt_val_i = 1'b0;
   logic [1:0]  mcdt_id_i = '0;
   logic        fmt_req_o;
   logic [1:0]  fmt_chid_o;
   logic        fmt_grant_i = 1'b0;
   logic [31:0] fmt_data_o;
   logic        fmt_valid_o;
   logic        fmt_ready_i = 1'b1;
   logic        fmt_start_o;
   logic        fmt_end_o;
   logic [2:0]  ovf_o;
   logic        id_err_o;

   int n_checks = 0;
   int n_fail   = 0;
   int acc_cnt  = 0;
   bit gnt_en    = 1'b1;
   bit toggle_en = 1'b0;
   bit mon_en    = 1'b1;
   beat_t sb [$];

   mcdt_formatter #(.FIFO_DEPTH(32), .PKT_LEN(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mcdt_data_i(mcdt_data_i), .mcdt_val_i(mcdt_val_i), .mcdt_id_i(mcdt_id_i),
      .fmt_req_o(fmt_req_o), .fmt_chid_o(fmt_chid_o), .fmt_grant_i(fmt_grant_i),
      .fmt_data_o(fmt_data_o), .fmt_valid_o(fmt_valid_o), .fmt_ready_i(fmt_ready_i),
      .fmt_start_o(fmt_start_o), .fmt_end_o(fmt_end_o),
      .ovf_o(ovf_o), .id_err_o(id_err_o)
   );

   initial forever #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic write(input logic [1:0] id, input logic [31:0] data);
      mcdt_val_i  = 1'b1;
      mcdt_id_i   = id;
      mcdt_data_i = data;
      @(posedge clk_i); #1;
      mcdt_val_i  = 1'b0;
   endtask

   task automatic expect_packet(input logic [1:0] ch, input logic [31:0] base);
      sb.push_back('{data: {8'hA5, 6'h0, ch, 8'h00, 8'h04}, start: 1'b1, last: 1'b0, chid: ch});
      for (int i = 0; i < 4; i++)
         sb.push_back('{data: base + 32'(i), start: 1'b0, last: (i == 3), chid: ch});
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk_i); #1;
         if (sb.size() == 0 && !fmt_valid_o && !fmt_req_o) break;
      end
      check("drain_sb_empty", 32'(sb.size()), 32'd0);
   endtask

   // Grant driver: one-cycle grant on the second cycle of a request.
   initial begin
      int wait_cnt = 0;
      forever begin
         @(posedge clk_i); #1;
         fmt_grant_i = 1'b0;
         if (gnt_en && fmt_req_o) begin
            wait_cnt++;
            if (wait_cnt == 2) begin
               fmt_grant_i = 1'b1;
               wait_cnt = 0;
            end
         end else wait_cnt = 0;
      end
   end

   initial begin
      forever begin
         @(posedge clk_i); #1;
         fmt_ready_i = toggle_en ? ~fmt_ready_i : 1'b1;
      end
   end

   // Monitor: compares accepted words with the scoreboard and checks stall stability.
   initial begin
      beat_t exp_b;
      beat_t held;
      bit    held_v = 1'b0;
      forever begin
         @(negedge clk_i);
         if (mon_en && held_v) begin
            check("hold_valid", {31'd0, fmt_valid_o}, 32'd1);
            check("hold_word", {fmt_data_o}, held.data);
            check("hold_flags", {30'd0, fmt_start_o, fmt_end_o}, {30'd0, held.start, held.last});
         end
         held_v = 1'b0;
         if (mon_en && fmt_valid_o) begin
            if (fmt_ready_i) begin
               acc_cnt++;
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_underflow: got unexpected word 0x%08h, expected none", fmt_data_o);
               end else begin
                  exp_b = sb.pop_front();
                  check("out_data", fmt_data_o, exp_b.data);
                  check("out_flags", {28'd0, fmt_start_o, fmt_end_o, fmt_chid_o},
                        {28'd0, exp_b.start, exp_b.last, exp_b.chid});
               end
            end else begin
               held   = '{data: fmt_data_o, start: fmt_start_o, last: fmt_end_o, chid: fmt_chid_o};
               held_v = 1'b1;
            end
         end
      end
   end

   initial begin
      int acc_before;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      check("rst_req", {31'd0, fmt_req_o}, 32'd0);
      check("rst_valid", {31'd0, fmt_valid_o}, 32'd0);
      check("rst_data", fmt_data_o, 32'd0);
      check("rst_flags", {27'd0, fmt_start_o, fmt_end_o, fmt_chid_o, id_err_o}, 32'd0);
      check("rst_ovf", {29'd0, ovf_o}, 32'd0);

      // Single packet on ch0 with request timing.
      expect_packet(2'd0, 32'h00C0_0000);
      for (int i = 0; i < 4; i++) write(2'd0, 32'h00C0_0000 + 32'(i));
      check("req_not_yet", {31'd0, fmt_req_o}, 32'd0);
      @(posedge clk_i); #1;
      check("req_asserted", {31'd0, fmt_req_o}, 32'd1);
      check("req_chid", {30'd0, fmt_chid_o}, 32'd0);
      wait_drain(100);

      // All three channels pending before any grant: round-robin order 0,1,2.
      gnt_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         expect_packet(2'(c), 32'h00C0_0000 + (32'(c) << 16));
         for (int i = 0; i < 4; i++) write(2'(c), 32'h00C0_0000 + (32'(c) << 16) + 32'(i));
      end
      gnt_en = 1'b1;
      wait_drain(200);

      // Ready toggling during a packet.
      toggle_en  = 1'b1;
      acc_before = acc_cnt;
      expect_packet(2'd1, 32'h1111_0000);
      for (int i = 0; i < 4; i++) write(2'd1, 32'h1111_0000 + 32'(i));
      wait_drain(200);
      check("toggle_accepts", 32'(acc_cnt - acc_before), 32'd5);
      toggle_en = 1'b0;
      @(posedge clk_i); #1;

      // Overflow on ch2: 33rd word dropped, 32 words drain as 8 packets.
      gnt_en = 1'b0;
      for (int k = 0; k < 8; k++) expect_packet(2'd2, 32'h00C2_0000 + 32'(4 * k));
      for (int i = 0; i < 33; i++) write(2'd2, 32'h00C2_0000 + 32'(i));
      check("ovf_ch2", {29'd0, ovf_o}, 32'd4);
      gnt_en = 1'b1;
      wait_drain(1000);

      // Illegal id.
      write(2'd3, 32'hDEAD_BEEF);
      @(posedge clk_i); #1;
      check("id_err", {31'd0, id_err_o}, 32'd1);
      for (int c = 0; c < 3; c++) check("id3_cnt", 32'(dut.cnt_q[c]), 32'd0);
      check("id3_no_req", {31'd0, fmt_req_o}, 32'd0);

      // Reset during DATA beat 2.
      mon_en = 1'b0;
      for (int i = 0; i < 4; i++) write(2'd0, 32'h00C0_0000 + 32'(i));
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk_i); #1;
            seen = fmt_valid_o && !fmt_start_o && (fmt_data_o == 32'h00C0_0002);
         end
         check("beat2_reached", {31'd0, seen}, 32'd1);
      end
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      check("mid_rst_outs", {fmt_data_o}, 32'd0);
      check("mid_rst_ctrl", {26'd0, fmt_req_o, fmt_valid_o, fmt_start_o, fmt_end_o, fmt_chid_o}, 32'd0);
      check("mid_rst_sticky", {28'd0, ovf_o, id_err_o}, 32'd0);
      for (int c = 0; c < 3; c++) check("mid_rst_cnt", 32'(dut.cnt_q[c]), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
